// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg
//   Shared types and constants for the pipeline hazard controller:
//   register address width, the x0 register index, reset level,
//   FSM state encoding and the flush-counter type.
//   Ports: none (package).
package pipe_hazard_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t ZERO_REG   = '0;
  localparam logic      RST_ENABLE = 1'b0;   // rst_i is active-low

  typedef enum logic [1:0] {
    HAZ_RUN   = 2'd0,
    HAZ_HAZ   = 2'd1,
    HAZ_BUSY  = 2'd2,
    HAZ_FLUSH = 2'd3
  } haz_state_e;

  // FLUSH_LAT tops out at 7, so the reload value FLUSH_LAT-1 fits in 3 bits.
  localparam int FLUSH_CNT_W = 3;
  typedef logic [FLUSH_CNT_W-1:0] flush_cnt_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if
//   Bundle between the id stage and the hazard controller.
//   master : id-stage side, drives decode info and EX status, receives
//            stall/flush/issue controls.
//   slave  : the hazard controller.
//   Signals: id_valid_i, reg1_re_i, reg1_raddr_i, reg2_re_i, reg2_raddr_i,
//            reg_we_i, reg_waddr_i, ex_busy_i, branch_taken_i (to controller);
//            stall_if_o, stall_id_o, flush_if_o, flush_id_o, issue_o,
//            state_o (from controller).
interface pipe_hazard_ctrl_if;
  import pipe_hazard_ctrl_pkg::*;

  logic      id_valid_i;
  logic      reg1_re_i;
  reg_addr_t reg1_raddr_i;
  logic      reg2_re_i;
  reg_addr_t reg2_raddr_i;
  logic      reg_we_i;
  reg_addr_t reg_waddr_i;
  logic      ex_busy_i;
  logic      branch_taken_i;

  logic       stall_if_o;
  logic       stall_id_o;
  logic       flush_if_o;
  logic       flush_id_o;
  logic       issue_o;
  logic [1:0] state_o;

  modport master (
    output id_valid_i, reg1_re_i, reg1_raddr_i, reg2_re_i, reg2_raddr_i,
           reg_we_i, reg_waddr_i, ex_busy_i, branch_taken_i,
    input  stall_if_o, stall_id_o, flush_if_o, flush_id_o, issue_o, state_o
  );

  modport slave (
    input  id_valid_i, reg1_re_i, reg1_raddr_i, reg2_re_i, reg2_raddr_i,
           reg_we_i, reg_waddr_i, ex_busy_i, branch_taken_i,
    output stall_if_o, stall_id_o, flush_if_o, flush_id_o, issue_o, state_o
  );

endinterface

// File: rtl/pipe_hazard_ctrl_sb.sv
// pipe_hazard_ctrl_sb (hazard scoreboard)
//   Shift register of in-flight register writes, one entry per cycle
//   between ID issue and regfile write, plus two address comparators.
//   Ports:
//     clk_i, rst_i        clock, synchronous active-low reset
//     shift_en            advance the pipe (low while EX is frozen)
//     push_valid/addr     new entry0 contents
//     q1_addr, q2_addr    source addresses to look up
//     q1_match, q2_match  address matches some valid entry
module pipe_hazard_ctrl_sb
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int WB_DEPTH = 3
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      shift_en,
  input  logic      push_valid,
  input  reg_addr_t push_addr,
  input  reg_addr_t q1_addr,
  input  reg_addr_t q2_addr,
  output logic      q1_match,
  output logic      q2_match
);

  logic [WB_DEPTH-1:0] valid_q;
  reg_addr_t           addr_q [WB_DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i == RST_ENABLE) begin
      valid_q <= '0;
    end else if (shift_en) begin
      for (int k = WB_DEPTH - 1; k > 0; k--) valid_q[k] <= valid_q[k-1];
      valid_q[0] <= push_valid;
    end
  end

  // Address payload needs no reset; it is qualified by valid_q.
  always_ff @(posedge clk_i) begin
    if (shift_en) begin
      for (int k = WB_DEPTH - 1; k > 0; k--) addr_q[k] <= addr_q[k-1];
      addr_q[0] <= push_addr;
    end
  end

  // The last entry is included: the regfile has no write-through, so the
  // value is not readable until the cycle after it retires.
  always_comb begin
    q1_match = 1'b0;
    q2_match = 1'b0;
    for (int k = 0; k < WB_DEPTH; k++) begin
      if (valid_q[k] && (addr_q[k] == q1_addr)) q1_match = 1'b1;
      if (valid_q[k] && (addr_q[k] == q2_addr)) q2_match = 1'b1;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Pipeline sequencer for the in-order core (no forwarding). Stalls if/id
//   on RAW hazards against in-flight writes, freezes the pipe while a
//   multi-cycle EX op runs, and flushes if/id for FLUSH_LAT extra cycles
//   after a taken branch.
//   Ports:
//     clk_i   core clock
//     rst_i   synchronous active-low reset
//     bus     pipe_hazard_ctrl_if.slave (decode info in, stall/flush out)
//   Optional (macro HAZARD_STATS_EN): haz_cnt_o, busy_cnt_o, flush_cnt_o,
//     32-bit wrap-around event counters.
//
//   state     | meaning
//   ----------+-----------------------------------------------
//   HAZ_RUN   | normal issue
//   HAZ_HAZ   | last cycle stalled on a RAW hazard
//   HAZ_BUSY  | last cycle frozen by a multi-cycle EX op
//   HAZ_FLUSH | flushing if/id after a redirect
//
//   Outputs are combinational from inputs, state and flush counter; the
//   state only selects the FLUSH behaviour and is otherwise informational.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int WB_DEPTH  = 3,
  parameter int FLUSH_LAT = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  pipe_hazard_ctrl_if.slave bus
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0] haz_cnt_o,
  output logic [31:0] busy_cnt_o,
  output logic [31:0] flush_cnt_o
`endif
);

  localparam bit         HAS_FLUSH    = (FLUSH_LAT > 0);
  localparam flush_cnt_t FLUSH_RELOAD = HAS_FLUSH ? flush_cnt_t'(FLUSH_LAT - 1) : '0;

  haz_state_e state_q;
  flush_cnt_t flush_cnt_q;

  logic m1, m2, haz;
  logic sb_shift, sb_push;
  logic issue, stall_if, stall_id, flush_if, flush_id;
  logic haz_stall, busy_stall;

  pipe_hazard_ctrl_sb #(
    .WB_DEPTH (WB_DEPTH)
  ) u_hazard_sb (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .shift_en   (sb_shift),
    .push_valid (sb_push),
    .push_addr  (bus.reg_waddr_i),
    .q1_addr    (bus.reg1_raddr_i),
    .q2_addr    (bus.reg2_raddr_i),
    .q1_match   (m1),
    .q2_match   (m2)
  );

  assign haz = bus.id_valid_i &
               ((bus.reg1_re_i & (bus.reg1_raddr_i != ZERO_REG) & m1) |
                (bus.reg2_re_i & (bus.reg2_raddr_i != ZERO_REG) & m2));

  always_comb begin
    issue      = 1'b0;
    stall_if   = 1'b0;
    stall_id   = 1'b0;
    flush_if   = 1'b0;
    flush_id   = 1'b0;
    sb_shift   = 1'b1;
    sb_push    = 1'b0;
    haz_stall  = 1'b0;
    busy_stall = 1'b0;
    if (rst_i == RST_ENABLE) begin
      flush_if = 1'b1;
      flush_id = 1'b1;
    end else if (bus.branch_taken_i || (state_q == HAZ_FLUSH)) begin
      flush_if = 1'b1;
      flush_id = 1'b1;
    end else if (bus.ex_busy_i) begin
      stall_if   = 1'b1;
      stall_id   = 1'b1;
      sb_shift   = 1'b0;
      busy_stall = 1'b1;
    end else if (haz) begin
      // Bubble into EX so the stalled instruction is not issued twice.
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      flush_id  = 1'b1;
      haz_stall = 1'b1;
    end else begin
      issue   = bus.id_valid_i;
      sb_push = bus.id_valid_i & bus.reg_we_i & (bus.reg_waddr_i != ZERO_REG);
    end
  end

  assign bus.issue_o    = issue;
  assign bus.stall_if_o = stall_if;
  assign bus.stall_id_o = stall_id;
  assign bus.flush_if_o = flush_if;
  assign bus.flush_id_o = flush_id;
  assign bus.state_o    = (rst_i == RST_ENABLE) ? HAZ_RUN : state_q;

  always_ff @(posedge clk_i) begin
    if (rst_i == RST_ENABLE) begin
      state_q     <= HAZ_RUN;
      flush_cnt_q <= '0;
    end else if (bus.branch_taken_i) begin
      // A redirect during FLUSH simply reloads the counter.
      if (HAS_FLUSH) begin
        state_q     <= HAZ_FLUSH;
        flush_cnt_q <= FLUSH_RELOAD;
      end else begin
        state_q <= HAZ_RUN;
      end
    end else if (state_q == HAZ_FLUSH) begin
      if (flush_cnt_q == '0) state_q <= HAZ_RUN;
      else                   flush_cnt_q <= flush_cnt_q - 1'b1;
    end else if (bus.ex_busy_i) begin
      state_q <= HAZ_BUSY;
    end else if (haz) begin
      state_q <= HAZ_HAZ;
    end else begin
      state_q <= HAZ_RUN;
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk_i) begin
    if (rst_i == RST_ENABLE) begin
      haz_cnt_o   <= '0;
      busy_cnt_o  <= '0;
      flush_cnt_o <= '0;
    end else begin
      haz_cnt_o   <= haz_cnt_o   + 32'(haz_stall);
      busy_cnt_o  <= busy_cnt_o  + 32'(busy_stall);
      flush_cnt_o <= flush_cnt_o + 32'(bus.branch_taken_i);
    end
  end
`endif

endmodule
